// File: rtl/axi_deserializer_pkg.sv
// rtl/axi_deserializer_pkg.sv - shared helpers for the serial-to-parallel packer
package axi_deserializer_pkg;

    // Accumulator position for bit number cnt of a word.
    // When rev is 0, the first bit lands in the MSB.
    // When rev is 1, the first bit lands in the LSB.
    function automatic int unsigned bit_pos(
        input int unsigned cnt,
        input logic        rev,
        input int unsigned width
    );
        return rev ? cnt : (width - 1 - cnt);
    endfunction

endpackage

// File: rtl/axi_deserializer.sv
// rtl/axi_deserializer.sv - packs a 1-bit AXI-Stream into WIDTH-bit words with tlast/tuser
module axi_deserializer
    import axi_deserializer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reverse_output,
    input  logic                       i_tdata,
    input  logic                       i_tlast,
    input  logic                       i_tvalid,
    output logic                       i_tready,
    output logic [WIDTH-1:0]           o_tdata,
    output logic [$clog2(WIDTH+1)-1:0] o_tuser,
    output logic                       o_tlast,
    output logic                       o_tvalid,
    input  logic                       o_tready
);

    localparam int CW = $clog2(WIDTH);
    localparam int UW = $clog2(WIDTH+1);

    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             rev_l;
    logic             acc_full;
    logic [UW-1:0]    held_user;
    logic             held_last;

    logic             in_fire;
    logic             out_free;
    logic             rev_eff;
    logic             word_done;
    logic [WIDTH-1:0] word_new;
    logic [UW-1:0]    user_new;
    logic             load_new;
    logic             load_held;
    logic             acc_full_next;

    // Placement of the incoming bit and the completion and handoff decisions.
    // The first bit of a word uses the live reverse_output, because that is
    // the same value being latched into rev_l.
    always_comb begin
        in_fire       = i_tvalid & i_tready;
        out_free      = ~o_tvalid | o_tready;
        rev_eff       = (cnt == '0) ? reverse_output : rev_l;
        word_new      = acc | ({{(WIDTH-1){1'b0}}, i_tdata}
                               << bit_pos(32'(cnt), rev_eff, WIDTH));
        user_new      = UW'(cnt) + UW'(1);
        word_done     = in_fire & ((cnt == CW'(WIDTH-1)) | i_tlast);
        load_new      = word_done & out_free;
        load_held     = acc_full & o_tready;
        acc_full_next = acc_full ? ~o_tready : (word_done & ~out_free);
    end

    // Accumulator, bit counter, held-word flag and registered input ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            rev_l     <= 1'b0;
            acc_full  <= 1'b0;
            held_user <= '0;
            held_last <= 1'b0;
            i_tready  <= 1'b0;
        end else begin
            // Ready drops on the same edge a word gets parked.
            // This prevents a bit from arriving while acc is occupied.
            i_tready <= ~acc_full_next;
            if (load_held) begin
                acc      <= '0;
                acc_full <= 1'b0;
            end else if (in_fire) begin
                if (cnt == '0) begin
                    rev_l <= reverse_output;
                end
                if (word_done) begin
                    cnt <= '0;
                    if (out_free) begin
                        acc <= '0;
                    end else begin
                        acc       <= word_new;
                        held_user <= user_new;
                        held_last <= i_tlast;
                        acc_full  <= 1'b1;
                    end
                end else begin
                    acc <= word_new;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // One-word output register.
    // It loads a fresh word or the parked word, and empties on an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_tdata  <= '0;
            o_tuser  <= '0;
            o_tlast  <= 1'b0;
            o_tvalid <= 1'b0;
        end else if (load_new) begin
            o_tdata  <= word_new;
            o_tuser  <= user_new;
            o_tlast  <= i_tlast;
            o_tvalid <= 1'b1;
        end else if (load_held) begin
            o_tdata  <= acc;
            o_tuser  <= held_user;
            o_tlast  <= held_last;
            o_tvalid <= 1'b1;
        end else if (o_tready) begin
            o_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_deserializer.sv
// tb/tb_axi_deserializer.sv - directed self-checking bench for axi_deserializer (WIDTH=8)
module tb_axi_deserializer;

    logic       clk;
    logic       rst;
    logic       reverse_output;
    logic       i_tdata;
    logic       i_tlast;
    logic       i_tvalid;
    logic       i_tready;
    logic [7:0] o_tdata;
    logic [3:0] o_tuser;
    logic       o_tlast;
    logic       o_tvalid;
    logic       o_tready;

    int passed = 0;
    int total  = 0;
    int stall_cycles = 0;
    int cyc = 0;

    logic [7:0] q_data[$];
    logic [3:0] q_user[$];
    logic       q_last[$];

    axi_deserializer #(.WIDTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .reverse_output (reverse_output),
        .i_tdata        (i_tdata),
        .i_tlast        (i_tlast),
        .i_tvalid       (i_tvalid),
        .i_tready       (i_tready),
        .o_tdata        (o_tdata),
        .o_tuser        (o_tuser),
        .o_tlast        (o_tlast),
        .o_tvalid       (o_tvalid),
        .o_tready       (o_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record output words that will be accepted on the coming edge.
    // Inputs are driven at posedge+1, so they are settled at the negedge.
    always @(negedge clk) begin
        if (o_tvalid && o_tready && !rst) begin
            q_data.push_back(o_tdata);
            q_user.push_back(o_tuser);
            q_last.push_back(o_tlast);
        end
    end

    task automatic clear_q();
        q_data.delete();
        q_user.delete();
        q_last.delete();
    endtask

    // Present one bit and return #1 after the edge that accepted it.
    task automatic send_bit(input logic b, input logic last);
        int waitc;
        i_tdata  = b;
        i_tlast  = last;
        i_tvalid = 1'b1;
        waitc    = 0;
        while (!i_tready && waitc < 100) begin
            @(posedge clk); #1;
            waitc++;
            stall_cycles++;
        end
        if (!i_tready) begin
            total++;
            $display("FAIL send_bit_timeout: i_tready=%b required 1", i_tready);
        end
        @(posedge clk); #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_tdata  = 1'b0;
    endtask

    // Send n bits taken MSB-first from w; tlast goes on the final bit if last is set.
    task automatic send_word(input logic [7:0] w, input int n, input logic last);
        for (int i = 0; i < n; i++) begin
            send_bit(w[7-i], last && (i == n-1));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reverse_output = 1'b0;
        i_tdata = 1'b0;
        i_tlast = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({i_tready, o_tdata, o_tuser, o_tlast, o_tvalid} !== 15'd0) begin
            $display("FAIL reset_outputs: got rdy=%b d=%h u=%0d l=%b v=%b required all 0",
                     i_tready, o_tdata, o_tuser, o_tlast, o_tvalid);
        end else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (i_tready !== 1'b1 || o_tvalid !== 1'b0) begin
            $display("FAIL reset_release: got rdy=%b v=%b required rdy=1 v=0", i_tready, o_tvalid);
        end else passed++;
    endtask

    task automatic test_basic();
        logic [7:0] pat   [4] = '{8'b10100101, 8'b10100101, 8'b11000000, 8'b11000000};
        logic       rev   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] expd  [4] = '{8'hA5, 8'hA5, 8'hC0, 8'h03};
        o_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            reverse_output = rev[k];
            send_word(pat[k], 8, 1'b0);
            total++;
            if (o_tvalid !== 1'b1 || o_tdata !== expd[k] || o_tuser !== 4'd8 || o_tlast !== 1'b0) begin
                $display("FAIL basic_word%0d: got v=%b d=%h u=%0d l=%b required v=1 d=%h u=8 l=0",
                         k, o_tvalid, o_tdata, o_tuser, o_tlast, expd[k]);
            end else passed++;
        end
        @(posedge clk); #1;
        total++;
        if (o_tvalid !== 1'b0) begin
            $display("FAIL basic_valid_drop: got v=%b required 0", o_tvalid);
        end else passed++;
    endtask

    task automatic test_tlast();
        o_tready = 1'b1;
        reverse_output = 1'b0;
        send_word(8'b11100000, 3, 1'b1);
        total++;
        if (o_tvalid !== 1'b1 || o_tdata !== 8'hE0 || o_tuser !== 4'd3 || o_tlast !== 1'b1) begin
            $display("FAIL tlast_short: got v=%b d=%h u=%0d l=%b required v=1 d=e0 u=3 l=1",
                     o_tvalid, o_tdata, o_tuser, o_tlast);
        end else passed++;
        send_word(8'hA5, 8, 1'b0);
        total++;
        if (o_tvalid !== 1'b1 || o_tdata !== 8'hA5 || o_tuser !== 4'd8 || o_tlast !== 1'b0) begin
            $display("FAIL tlast_next_word: got v=%b d=%h u=%0d l=%b required v=1 d=a5 u=8 l=0",
                     o_tvalid, o_tdata, o_tuser, o_tlast);
        end else passed++;
        reverse_output = 1'b1;
        send_bit(1'b1, 1'b1);
        total++;
        if (o_tvalid !== 1'b1 || o_tdata !== 8'h01 || o_tuser !== 4'd1 || o_tlast !== 1'b1) begin
            $display("FAIL tlast_single_rev1: got v=%b d=%h u=%0d l=%b required v=1 d=01 u=1 l=1",
                     o_tvalid, o_tdata, o_tuser, o_tlast);
        end else passed++;
        reverse_output = 1'b0;
        send_bit(1'b1, 1'b1);
        total++;
        if (o_tdata !== 8'h80 || o_tuser !== 4'd1 || o_tlast !== 1'b1) begin
            $display("FAIL tlast_single_rev0: got d=%h u=%0d l=%b required d=80 u=1 l=1",
                     o_tdata, o_tuser, o_tlast);
        end else passed++;
        send_word(8'b00001111, 8, 1'b1);
        total++;
        if (o_tdata !== 8'h0F || o_tuser !== 4'd8 || o_tlast !== 1'b1) begin
            $display("FAIL tlast_full: got d=%h u=%0d l=%b required d=0f u=8 l=1",
                     o_tdata, o_tuser, o_tlast);
        end else passed++;
    endtask

    task automatic test_rev_midword();
        o_tready = 1'b1;
        reverse_output = 1'b0;
        send_bit(1'b1, 1'b0);
        reverse_output = 1'b1;
        send_word(8'h00, 7, 1'b0);
        total++;
        if (o_tdata !== 8'h80) begin
            $display("FAIL rev_midword_ignored: got d=%h required 80", o_tdata);
        end else passed++;
        send_word(8'b10000000, 8, 1'b0);
        total++;
        if (o_tdata !== 8'h01) begin
            $display("FAIL rev_next_word: got d=%h required 01", o_tdata);
        end else passed++;
        reverse_output = 1'b0;
    endtask

    task automatic test_backpressure();
        int bad;
        @(posedge clk); #1;
        clear_q();
        o_tready = 1'b0;
        reverse_output = 1'b0;
        send_word(8'hA5, 8, 1'b0);
        send_word(8'h3C, 8, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i_tready !== 1'b0 || o_tvalid !== 1'b1 || o_tdata !== 8'hA5 || o_tuser !== 4'd8) bad++;
            @(posedge clk); #1;
        end
        total++;
        if (bad != 0) begin
            $display("FAIL bp_hold: %0d bad cycles (last rdy=%b v=%b d=%h) required 0",
                     bad, i_tready, o_tvalid, o_tdata);
        end else passed++;
        o_tready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (i_tready !== 1'b1 || o_tvalid !== 1'b1 || o_tdata !== 8'h3C) begin
            $display("FAIL bp_release: got rdy=%b v=%b d=%h required rdy=1 v=1 d=3c",
                     i_tready, o_tvalid, o_tdata);
        end else passed++;
        @(posedge clk); #1;
        send_word(8'h5A, 8, 1'b1);
        @(posedge clk); #1;
        total++;
        if (q_data.size() != 3) begin
            $display("FAIL bp_count: got %0d words required 3", q_data.size());
        end else if (q_data[0] !== 8'hA5 || q_data[1] !== 8'h3C || q_data[2] !== 8'h5A
                     || q_last[2] !== 1'b1 || q_last[0] !== 1'b0) begin
            $display("FAIL bp_order: got %h %h %h last=%b required a5 3c 5a last=1",
                     q_data[0], q_data[1], q_data[2], q_last[2]);
        end else passed++;
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        o_tready = 1'b1;
        reverse_output = 1'b0;
        @(posedge clk); #1;
        clear_q();
        stall_cycles = 0;
        c0 = cyc;
        send_word(8'h12, 8, 1'b0);
        send_word(8'h34, 8, 1'b0);
        send_word(8'h56, 8, 1'b1);
        c1 = cyc;
        @(posedge clk); #1;
        total++;
        if (stall_cycles != 0 || (c1 - c0) != 24) begin
            $display("FAIL b2b_throughput: got stalls=%0d cycles=%0d required 0 and 24",
                     stall_cycles, c1 - c0);
        end else passed++;
        total++;
        if (q_data.size() != 3) begin
            $display("FAIL b2b_count: got %0d words required 3", q_data.size());
        end else if (q_data[0] !== 8'h12 || q_data[1] !== 8'h34 || q_data[2] !== 8'h56
                     || q_user[0] !== 4'd8 || q_user[2] !== 4'd8 || q_last[2] !== 1'b1) begin
            $display("FAIL b2b_data: got %h %h %h u=%0d l=%b required 12 34 56 u=8 l=1",
                     q_data[0], q_data[1], q_data[2], q_user[2], q_last[2]);
        end else passed++;
    endtask

    task automatic test_mid_reset();
        o_tready = 1'b1;
        reverse_output = 1'b0;
        @(posedge clk); #1;
        send_word(8'hF0, 4, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        clear_q();
        total++;
        if ({i_tready, o_tdata, o_tuser, o_tlast, o_tvalid} !== 15'd0) begin
            $display("FAIL midreset_outputs: got rdy=%b d=%h u=%0d l=%b v=%b required all 0",
                     i_tready, o_tdata, o_tuser, o_tlast, o_tvalid);
        end else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (i_tready !== 1'b1) begin
            $display("FAIL midreset_ready: got %b required 1", i_tready);
        end else passed++;
        send_word(8'hA5, 8, 1'b0);
        @(posedge clk); #1;
        total++;
        if (q_data.size() != 1) begin
            $display("FAIL midreset_count: got %0d words required 1", q_data.size());
        end else if (q_data[0] !== 8'hA5 || q_user[0] !== 4'd8) begin
            $display("FAIL midreset_word: got d=%h u=%0d required a5 u=8", q_data[0], q_user[0]);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tlast();
        test_rev_midword();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
